// File: rtl/vlan_pkt_filter_pkg.sv
// Shared constants and types for the VLAN ingress filter: header byte offsets,
// match values, FSM state and packet class enums.
package vlan_pkt_filter_pkg;

  localparam int OFF_ETH_TYPE   = 12;
  localparam int OFF_VLAN_TCI   = 14;
  localparam int OFF_INNER_TYPE = 16;
  localparam int OFF_IP_PROTO   = 27;
  localparam int OFF_CTRL_FLAG  = 40;

  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] CTRL_FLAG     = 16'hf2f1;

  localparam int VID_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    FWD_DATA,
    FWD_CTRL,
    DROP
  } state_t;

  typedef enum logic [1:0] {
    CLS_DATA,
    CLS_CTRL,
    CLS_DROP
  } cls_t;

endpackage

// File: rtl/vlan_pkt_filter_if.sv
// AXI-Stream bundle used for the ingress, data and control streams.
// master_nr is the producer view for streams without back-pressure.
interface vlan_pkt_filter_if #(
  parameter int DW = 512,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [UW-1:0]   tuser;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata, tuser, tkeep, tvalid, tlast,
    input  tready
  );

  modport master_nr (
    output tdata, tuser, tkeep, tvalid, tlast
  );

  modport slave (
    input  tdata, tuser, tkeep, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/vlan_pkt_filter_classify.sv
// Combinational first-beat decode: extracts the header fields and reduces them
// to a packet class plus the 12-bit VLAN ID.
module vlan_pkt_classify
  import vlan_pkt_filter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 512
) (
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] i_tdata,
  output cls_t                           o_cls,
  output logic [VID_W-1:0]               o_vid
);

  logic [15:0] w_eth_type;
  logic [15:0] w_inner_type;
  logic [15:0] w_ctrl_flag;
  logic [7:0]  w_ip_proto;
  logic        w_is_vlan_ipv4;

  // Ethertypes are big-endian on the wire; the control flag is compared raw.
  assign w_eth_type     = {i_tdata[OFF_ETH_TYPE*8 +: 8], i_tdata[(OFF_ETH_TYPE+1)*8 +: 8]};
  assign w_inner_type   = {i_tdata[OFF_INNER_TYPE*8 +: 8], i_tdata[(OFF_INNER_TYPE+1)*8 +: 8]};
  assign w_ip_proto     = i_tdata[OFF_IP_PROTO*8 +: 8];
  assign w_ctrl_flag    = i_tdata[OFF_CTRL_FLAG*8 +: 16];
  assign o_vid          = {i_tdata[OFF_VLAN_TCI*8 +: 4], i_tdata[(OFF_VLAN_TCI+1)*8 +: 8]};
  assign w_is_vlan_ipv4 = (w_eth_type == ETH_TYPE_VLAN) && (w_inner_type == ETH_TYPE_IPV4);

  always_comb begin
    o_cls = CLS_DROP;
    if (w_is_vlan_ipv4) begin
      if ((w_ip_proto == IP_PROTO_UDP) && (w_ctrl_flag == CTRL_FLAG))
        o_cls = CLS_CTRL;
      else
        o_cls = CLS_DATA;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, i_tdata[95:0], i_tdata[119:116], i_tdata[215:144],
                      i_tdata[319:224], i_tdata[C_S_AXIS_DATA_WIDTH-1:336]};

endmodule

// File: rtl/vlan_pkt_filter.sv
// VLAN ingress filter: routes tagged IPv4 data to the parser data stream, UDP
// control frames to the ctrl stream, drops the rest. VLAN_PKT_FILTER_STATS_EN adds packet counters.
module vlan_pkt_filter
  import vlan_pkt_filter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_VLANID_WIDTH       = 12
) (
  input  logic                      axis_clk,
  input  logic                      aresetn,
  vlan_pkt_filter_if.slave          s_axis,
  vlan_pkt_filter_if.master         m_axis,
  vlan_pkt_filter_if.master_nr      ctrl_m_axis,
  output logic [C_VLANID_WIDTH-1:0] m_vlan_id,
  output logic                      m_vlan_id_valid
`ifdef VLAN_PKT_FILTER_STATS_EN
  ,
  output logic [31:0]               stat_data_pkts,
  output logic [31:0]               stat_ctrl_pkts,
  output logic [31:0]               stat_drop_pkts
`endif
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  state_t                          r_state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  r_m_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
  logic [KW-1:0]                   r_m_tkeep;
  logic                            r_m_tvalid;
  logic                            r_m_tlast;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  r_c_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] r_c_tuser;
  logic [KW-1:0]                   r_c_tkeep;
  logic                            r_c_tvalid;
  logic                            r_c_tlast;
  logic [C_VLANID_WIDTH-1:0]       r_vid;
  logic                            r_vid_valid;

  cls_t                            w_cls;
  logic [VID_W-1:0]                w_vid;
  logic                            w_s_tready;
  logic                            w_accept;
  logic                            w_accept_last;

  vlan_pkt_classify #(
    .C_S_AXIS_DATA_WIDTH(C_S_AXIS_DATA_WIDTH)
  ) u_classify (
    .i_tdata (s_axis.tdata),
    .o_cls   (w_cls),
    .o_vid   (w_vid)
  );

  // Only streams that land in the data register see back-pressure.
  always_comb begin
    w_s_tready = 1'b1;
    if ((r_state == IDLE) || (r_state == FWD_DATA))
      w_s_tready = !r_m_tvalid || m_axis.tready;
  end

  assign w_accept      = s_axis.tvalid && w_s_tready;
  assign w_accept_last = w_accept && s_axis.tlast;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_m_tdata   <= '0;
      r_m_tuser   <= '0;
      r_m_tkeep   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_c_tdata   <= '0;
      r_c_tuser   <= '0;
      r_c_tkeep   <= '0;
      r_c_tvalid  <= 1'b0;
      r_c_tlast   <= 1'b0;
      r_vid       <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_c_tdata   <= s_axis.tdata;
      r_c_tuser   <= s_axis.tuser;
      r_c_tkeep   <= s_axis.tkeep;
      r_c_tlast   <= s_axis.tlast;
      r_c_tvalid  <= 1'b0;
      r_vid_valid <= 1'b0;
      if (m_axis.tready)
        r_m_tvalid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_cls)
              CLS_DATA: begin
                r_m_tdata   <= s_axis.tdata;
                r_m_tuser   <= s_axis.tuser;
                r_m_tkeep   <= s_axis.tkeep;
                r_m_tlast   <= s_axis.tlast;
                r_m_tvalid  <= 1'b1;
                r_vid       <= w_vid;
                r_vid_valid <= 1'b1;
                if (!s_axis.tlast)
                  r_state <= FWD_DATA;
              end
              CLS_CTRL: begin
                r_c_tvalid <= 1'b1;
                if (!s_axis.tlast)
                  r_state <= FWD_CTRL;
              end
              default: begin
                if (!s_axis.tlast)
                  r_state <= DROP;
              end
            endcase
          end
        end
        FWD_DATA: begin
          if (w_accept) begin
            r_m_tdata  <= s_axis.tdata;
            r_m_tuser  <= s_axis.tuser;
            r_m_tkeep  <= s_axis.tkeep;
            r_m_tlast  <= s_axis.tlast;
            r_m_tvalid <= 1'b1;
            if (s_axis.tlast)
              r_state <= IDLE;
          end
        end
        FWD_CTRL: begin
          if (w_accept) begin
            r_c_tvalid <= 1'b1;
            if (s_axis.tlast)
              r_state <= IDLE;
          end
        end
        default: begin
          if (w_accept_last)
            r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef VLAN_PKT_FILTER_STATS_EN
  logic [31:0] r_stat_data;
  logic [31:0] r_stat_ctrl;
  logic [31:0] r_stat_drop;
  cls_t        w_pkt_cls;

  // Packet class of the beat being accepted: decoded in IDLE, remembered otherwise.
  always_comb begin
    w_pkt_cls = w_cls;
    case (r_state)
      FWD_DATA: w_pkt_cls = CLS_DATA;
      FWD_CTRL: w_pkt_cls = CLS_CTRL;
      DROP:     w_pkt_cls = CLS_DROP;
      default:  w_pkt_cls = w_cls;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_data <= '0;
      r_stat_ctrl <= '0;
      r_stat_drop <= '0;
    end else if (w_accept_last) begin
      case (w_pkt_cls)
        CLS_DATA: r_stat_data <= r_stat_data + 32'd1;
        CLS_CTRL: r_stat_ctrl <= r_stat_ctrl + 32'd1;
        default:  r_stat_drop <= r_stat_drop + 32'd1;
      endcase
    end
  end

  assign stat_data_pkts = r_stat_data;
  assign stat_ctrl_pkts = r_stat_ctrl;
  assign stat_drop_pkts = r_stat_drop;
`endif

  assign s_axis.tready      = w_s_tready;
  assign m_axis.tdata       = r_m_tdata;
  assign m_axis.tuser       = r_m_tuser;
  assign m_axis.tkeep       = r_m_tkeep;
  assign m_axis.tvalid      = r_m_tvalid;
  assign m_axis.tlast       = r_m_tlast;
  assign ctrl_m_axis.tdata  = r_c_tdata;
  assign ctrl_m_axis.tuser  = r_c_tuser;
  assign ctrl_m_axis.tkeep  = r_c_tkeep;
  assign ctrl_m_axis.tvalid = r_c_tvalid;
  assign ctrl_m_axis.tlast  = r_c_tlast;
  assign m_vlan_id          = r_vid;
  assign m_vlan_id_valid    = r_vid_valid;

endmodule

// File: tb/tb_vlan_pkt_filter.sv
// Scoreboard bench for vlan_pkt_filter: directed packets push expected beats and
// VLAN IDs into queues; a monitor pops and compares on every egress event.
module tb_vlan_pkt_filter;

  typedef struct {
    logic [511:0] d;
    logic [127:0] u;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_data_seen = 0;
  int   n_ctrl_seen = 0;
  int   n_vid_seen = 0;

  beat_t       data_q[$];
  beat_t       ctrl_q[$];
  logic [11:0] vid_q[$];

  logic [11:0] m_vlan_id;
  logic        m_vlan_id_valid;
`ifdef VLAN_PKT_FILTER_STATS_EN
  logic [31:0] stat_data_pkts;
  logic [31:0] stat_ctrl_pkts;
  logic [31:0] stat_drop_pkts;
`endif

  vlan_pkt_filter_if #(.DW(512), .UW(128)) s_if ();
  vlan_pkt_filter_if #(.DW(512), .UW(128)) m_if ();
  vlan_pkt_filter_if #(.DW(512), .UW(128)) c_if ();

  assign c_if.tready = 1'b1;

  always #5 clk = ~clk;

  vlan_pkt_filter dut (
    .axis_clk        (clk),
    .aresetn         (rst_n),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .ctrl_m_axis     (c_if),
    .m_vlan_id       (m_vlan_id),
    .m_vlan_id_valid (m_vlan_id_valid)
`ifdef VLAN_PKT_FILTER_STATS_EN
    ,
    .stat_data_pkts  (stat_data_pkts),
    .stat_ctrl_pkts  (stat_ctrl_pkts),
    .stat_drop_pkts  (stat_drop_pkts)
`endif
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  function automatic logic [511:0] hdr(input logic [15:0] eth, input logic [11:0] vid,
                                       input logic [15:0] inner, input logic [7:0] proto,
                                       input logic [15:0] flag, input logic [31:0] tag);
    logic [511:0] d;
    d = {16{tag}};
    d[103:96]  = eth[15:8];
    d[111:104] = eth[7:0];
    d[115:112] = vid[11:8];
    d[127:120] = vid[7:0];
    d[135:128] = inner[15:8];
    d[143:136] = inner[7:0];
    d[223:216] = proto;
    d[335:320] = flag;
    return d;
  endfunction

  function automatic logic [511:0] payload(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  // kind: 0 = expect on data stream, 1 = expect on ctrl stream, 2 = dropped
  task automatic send_beat(input logic [511:0] d, input bit last, input int kind, output int waits);
    beat_t b;
    bit    rdy;
    b.d = d;
    b.u = {4{d[31:0]}};
    b.k = last ? 64'h00ff_ffff_ffff_ffff : '1;
    b.l = last;
    if (kind == 0) data_q.push_back(b);
    else if (kind == 1) ctrl_q.push_back(b);
    s_if.tdata  = b.d;
    s_if.tuser  = b.u;
    s_if.tkeep  = b.k;
    s_if.tlast  = b.l;
    s_if.tvalid = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        unexpected("ingress_accept_timeout");
        break;
      end
    end
  endtask

  task automatic idle_in();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((data_q.size() != 0 || ctrl_q.size() != 0 || vid_q.size() != 0) && cyc < 30) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_data_q", 512'(data_q.size()), 512'd0);
    chk("drain_ctrl_q", 512'(ctrl_q.size()), 512'd0);
    chk("drain_vid_q", 512'(vid_q.size()), 512'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, 512'(m_if.tvalid), 512'd0);
    chk({tag, "_m_tlast"},  512'(m_if.tlast), 512'd0);
    chk({tag, "_m_tdata"},  m_if.tdata, 512'd0);
    chk({tag, "_m_tuser"},  512'(m_if.tuser), 512'd0);
    chk({tag, "_m_tkeep"},  512'(m_if.tkeep), 512'd0);
    chk({tag, "_c_tvalid"}, 512'(c_if.tvalid), 512'd0);
    chk({tag, "_c_tlast"},  512'(c_if.tlast), 512'd0);
    chk({tag, "_c_tdata"},  c_if.tdata, 512'd0);
    chk({tag, "_vid"},      512'(m_vlan_id), 512'd0);
    chk({tag, "_vid_vld"},  512'(m_vlan_id_valid), 512'd0);
    chk({tag, "_s_tready"}, 512'(s_if.tready), 512'd1);
  endtask

  // Monitor: egress events are sampled on the falling edge.
  initial begin
    logic [511:0] prev_d;
    bit           prev_stall;
    beat_t        e;
    logic [11:0]  ev;
    prev_stall = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && rst_n) begin
        chk("hold_tvalid", 512'(m_if.tvalid), 512'd1);
        chk("hold_tdata", m_if.tdata, prev_d);
      end
      if (m_if.tvalid && m_if.tready) begin
        n_data_seen++;
        if (data_q.size() == 0) unexpected("data_beat");
        else begin
          e = data_q.pop_front();
          chk("data_tdata", m_if.tdata, e.d);
          chk("data_tuser", 512'(m_if.tuser), 512'(e.u));
          chk("data_tkeep", 512'(m_if.tkeep), 512'(e.k));
          chk("data_tlast", 512'(m_if.tlast), 512'(e.l));
        end
      end
      if (m_vlan_id_valid) begin
        n_vid_seen++;
        chk("vid_with_tvalid", 512'(m_if.tvalid), 512'd1);
        if (vid_q.size() == 0) unexpected("vid_strobe");
        else begin
          ev = vid_q.pop_front();
          chk("vid_value", 512'(m_vlan_id), 512'(ev));
        end
      end
      if (c_if.tvalid) begin
        n_ctrl_seen++;
        if (ctrl_q.size() == 0) unexpected("ctrl_beat");
        else begin
          e = ctrl_q.pop_front();
          chk("ctrl_tdata", c_if.tdata, e.d);
          chk("ctrl_tlast", 512'(c_if.tlast), 512'(e.l));
          chk("ctrl_tkeep", 512'(c_if.tkeep), 512'(e.k));
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d = m_if.tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w4;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tkeep  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-beat tagged IPv4/TCP data packet
    vid_q.push_back(12'h005);
    send_beat(hdr(16'h8100, 12'h005, 16'h0800, 8'h06, 16'h0000, 32'h1111_0001), 1'b0, 0, w);
    send_beat(payload(32'h1111_0002), 1'b1, 0, w);
    idle_in();
    drain();

    // Single-beat control packet
    send_beat(hdr(16'h8100, 12'h3ff, 16'h0800, 8'h11, 16'hf2f1, 32'h2222_0001), 1'b1, 1, w);
    idle_in();
    drain();

    // Three-beat untagged packet is discarded without back-pressure
    send_beat(hdr(16'h0800, 12'h001, 16'h0800, 8'h11, 16'hf2f1, 32'h3333_0001), 1'b0, 2, w);
    chk("drop_rdy_b1", 512'(w), 512'd0);
    send_beat(payload(32'h3333_0002), 1'b0, 2, w);
    chk("drop_rdy_b2", 512'(w), 512'd0);
    send_beat(payload(32'h3333_0003), 1'b1, 2, w);
    chk("drop_rdy_b3", 512'(w), 512'd0);
    // Tagged but non-IPv4 inner type is discarded
    send_beat(hdr(16'h8100, 12'h004, 16'h86dd, 8'h11, 16'hf2f1, 32'h3333_0004), 1'b1, 2, w);
    chk("drop_rdy_v6", 512'(w), 512'd0);
    // UDP without the control flag is ordinary data
    vid_q.push_back(12'h123);
    send_beat(hdr(16'h8100, 12'h123, 16'h0800, 8'h11, 16'h1234, 32'h3333_0005), 1'b1, 0, w);
    idle_in();
    drain();

    // Back-pressure while the first data beat sits in the output register
    m_if.tready = 1'b0;
    vid_q.push_back(12'h077);
    send_beat(hdr(16'h8100, 12'h077, 16'h0800, 8'h06, 16'h0000, 32'h4444_0001), 1'b0, 0, w);
    fork
      send_beat(payload(32'h4444_0002), 1'b1, 0, w4);
      begin
        @(negedge clk);
        chk("stall_s_tready", 512'(s_if.tready), 512'd0);
        repeat (2) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    chk("stall_waits", 512'(w4), 512'd2);
    idle_in();
    drain();

    // Back-to-back single-beat packets after a clean reset
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    vid_q.push_back(12'h00a);
    send_beat(hdr(16'h8100, 12'h00a, 16'h0800, 8'h06, 16'h0000, 32'h5555_0001), 1'b1, 0, w);
    send_beat(hdr(16'h8100, 12'h00c, 16'h0800, 8'h11, 16'hf2f1, 32'h5555_0002), 1'b1, 1, w);
    vid_q.push_back(12'h00b);
    send_beat(hdr(16'h8100, 12'h00b, 16'h0800, 8'h06, 16'h0000, 32'h5555_0003), 1'b1, 0, w);
    idle_in();
    drain();
    chk("b2b_last_vid", 512'(m_vlan_id), 512'h00b);
`ifdef VLAN_PKT_FILTER_STATS_EN
    chk("stat_data", 512'(stat_data_pkts), 512'd2);
    chk("stat_ctrl", 512'(stat_ctrl_pkts), 512'd1);
    chk("stat_drop", 512'(stat_drop_pkts), 512'd0);
`endif

    // Reset in the middle of a four-beat data packet, then a control packet
    vid_q.push_back(12'h0c3);
    send_beat(hdr(16'h8100, 12'h0c3, 16'h0800, 8'h06, 16'h0000, 32'h6666_0001), 1'b0, 0, w);
    send_beat(payload(32'h6666_0002), 1'b0, 0, w);
    idle_in();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_beat(hdr(16'h8100, 12'h0c4, 16'h0800, 8'h11, 16'hf2f1, 32'h6666_0003), 1'b1, 1, w);
    idle_in();
    drain();

    chk("total_data_beats", 512'(n_data_seen), 512'd9);
    chk("total_ctrl_beats", 512'(n_ctrl_seen), 512'd3);
    chk("total_vid_strobes", 512'(n_vid_seen), 512'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
